// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds the MDU op encodings used by the decoder, the E pipe and md_ctrl,
// the default operation latencies, and the FSM state type.
package md_pkg;

  // MDU op encodings carried on md_op; 6 and 7 are no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Default busy-cycle counts and counter width.
  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned CNT_W_DEF    = 4;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  // MULT/MULTU/DIV/DIVU occupy the unit for several cycles (ops 0..3).
  function automatic logic md_is_multi(logic [2:0] op);
    return ~op[2];
  endfunction

  // DIV/DIVU within the multi-cycle group (ops 2,3).
  function automatic logic md_is_div(logic [2:0] op);
    return ~op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply / divide datapath for the MDU.
// Ports:
//   op_i     - latched MDU op (MULT, MULTU, DIV, DIVU; others give zero)
//   rs_i     - latched RS operand (multiplicand / dividend)
//   rt_i     - latched RT operand (multiplier / divisor)
//   hi_res_o - high product word, or remainder
//   lo_res_o - low product word, or quotient
//   div0_o   - divide op with a zero divisor; results must not be committed
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic [31:0] hi_res_o,
  output logic [31:0] lo_res_o,
  output logic        div0_o
);

  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        signed_div;
  logic        rs_neg;
  logic        rt_neg;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] divisor;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        div_zero;

  always_comb begin
    prod_u = {32'd0, rs_i} * {32'd0, rt_i};
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_s = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 with no special case.
    signed_div = (op_i == MD_DIV);
    rs_neg     = signed_div & rs_i[31];
    rt_neg     = signed_div & rt_i[31];
    rs_mag     = rs_neg ? (~rs_i + 32'd1) : rs_i;
    rt_mag     = rt_neg ? (~rt_i + 32'd1) : rt_i;
    div_zero   = (rt_i == 32'd0);
    // Keep the divider away from a zero divisor; the result is discarded anyway.
    divisor    = div_zero ? 32'd1 : rt_mag;
    quo_mag    = rs_mag / divisor;
    rem_mag    = rs_mag % divisor;
    quo        = (rs_neg ^ rt_neg) ? (~quo_mag + 32'd1) : quo_mag;
    rem        = rs_neg ? (~rem_mag + 32'd1) : rem_mag;

    hi_res_o = 32'd0;
    lo_res_o = 32'd0;
    div0_o   = 1'b0;
    case (op_i)
      MD_MULT:  {hi_res_o, lo_res_o} = prod_s;
      MD_MULTU: {hi_res_o, lo_res_o} = prod_u;
      MD_DIV, MD_DIVU: begin
        hi_res_o = rem;
        lo_res_o = quo;
        div0_o   = div_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// Sequencing controller for the E-stage multiply/divide unit.
// Latches operands for MULT/MULTU/DIV/DIVU, holds the unit busy for a fixed
// latency, then commits to HI/LO. MTHI/MTLO write HI/LO in a single edge.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-low reset
//   start    - E-stage MDU op valid this cycle
//   md_op    - MDU op encoding (see md_pkg)
//   rs_val   - forwarded RS operand
//   rt_val   - forwarded RT operand
//   md_use_D - D-stage instruction uses the MDU or HI/LO
//   cancel   - squash the E-stage op sampled this cycle
//   busy     - multi-cycle op in progress
//   stall_md - combinational stall request to the D/E register
//   hi, lo   - architectural HI/LO registers
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      rt_q, rt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [31:0] hi_res;
  logic [31:0] lo_res;
  logic        div0;
  logic        accept;

  md_arith u_arith (
    .op_i     (op_q),
    .rs_i     (rs_q),
    .rt_i     (rt_q),
    .hi_res_o (hi_res),
    .lo_res_o (lo_res),
    .div0_o   (div0)
  );

  assign accept = start & ~cancel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (md_is_multi(md_op)) begin
            op_d    = md_op;
            rs_d    = rs_val;
            rt_d    = rt_val;
            cnt_d   = md_is_div(md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            state_d = StRun;
          end else if (md_op == MD_MTHI) begin
            hi_d = rs_val;
          end else if (md_op == MD_MTLO) begin
            lo_d = rs_val;
          end
        end
      end
      StRun: begin
        // Any start seen here is ignored; the stall keeps legal code from issuing one.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StIdle;
          if (!div0) begin
            hi_d = hi_res;
            lo_d = lo_res;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == StRun);
  // Also stall on the issue cycle itself, before busy has risen.
  assign stall_md = md_use_D & (busy | (accept & md_is_multi(md_op)));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        cancel;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  md_ctrl #(
    .MULT_LAT (5),
    .DIV_LAT  (10),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .cancel   (cancel),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a countdown of remaining busy cycles plus pending operands.
  int          m_left;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  task automatic model_reset();
    m_left = 0; m_op = 0; m_a = 0; m_b = 0; m_hi = 0; m_lo = 0;
  endtask

  task automatic model_commit();
    longint      sa, sb, q, r, p;
    logic [63:0] pu;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    case (m_op)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin pu = {32'd0, m_a} * {32'd0, m_b}; {m_hi, m_lo} = pu; end
      3'd2: if (m_b != 0) begin
        q = sa / sb; r = sa % sb;
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3'd3: if (m_b != 0) begin
        m_lo = m_a / m_b; m_hi = m_a % m_b;
      end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) model_commit();
    end else if (start && !cancel) begin
      if (md_op <= 3'd3) begin
        m_op = md_op; m_a = rs_val; m_b = rt_val;
        m_left = (md_op >= 3'd2) ? 10 : 5;
      end else if (md_op == 3'd4) begin
        m_hi = rs_val;
      end else if (md_op == 3'd5) begin
        m_lo = rs_val;
      end
    end
  endtask

  function automatic logic model_stall();
    return md_use_D & ((m_left > 0) | (start & ~cancel & (md_op <= 3'd3)));
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; cancel = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt, hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp = 0; n_fail = 0;
    model_reset();

    vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[6] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[7] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};

    reset = 1'b0; start = 1'b0; md_op = 3'd0; rs_val = 0; rt_val = 0;
    md_use_D = 1'b0; cancel = 1'b0;
    #2;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_stall", {63'd0, stall_md}, 64'd0);
    step();
    reset = 1'b1;
    step();

    // Table-driven ops: exact busy length and results.
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_idle(n);
      check($sformatf("vec%0d_lat", i), 64'(n), 64'(vecs[i].lat));
      check($sformatf("vec%0d_hi", i), {32'd0, hi}, {32'd0, vecs[i].hi});
      check($sformatf("vec%0d_lo", i), {32'd0, lo}, {32'd0, vecs[i].lo});
    end

    // Divide by zero: HI/LO keep FFFFFFFE/00000001, timing unchanged.
    issue(3'd3, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_lat", 64'(n), 64'd10);
    check("divu0_hi", {32'd0, hi}, 64'hFFFFFFFE);
    check("divu0_lo", {32'd0, lo}, 64'h00000001);
    issue(3'd2, 32'hFFFFFFF9, 32'd0);
    wait_idle(n);
    check("div0_lat", 64'(n), 64'd10);
    check("div0_hi", {32'd0, hi}, 64'hFFFFFFFE);

    // Stall sequence with a stray start injected on busy cycle 3.
    md_use_D = 1'b1;
    start = 1'b1; md_op = 3'd0; rs_val = 32'hFFFFFFFE; rt_val = 32'd3;
    #1;
    check("stall_issue", {63'd0, stall_md}, 64'd1);
    step();
    for (int k = 1; k <= 5; k++) begin
      start = (k == 3);
      md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd3;
      #1;
      check($sformatf("stall_busy%0d", k), {62'd0, busy, stall_md}, 64'd3);
      step();
    end
    start = 1'b0;
    #1;
    check("stall_after", {62'd0, busy, stall_md}, 64'd0);
    check("stray_hi", {32'd0, hi}, 64'hFFFFFFFF);
    check("stray_lo", {32'd0, lo}, 64'hFFFFFFFA);
    md_use_D = 1'b0;

    // MTHI / MTLO and cancel.
    issue(3'd4, 32'h12345678, 32'd0);
    check("mthi_hi", {32'd0, hi}, 64'h12345678);
    check("mthi_lo", {32'd0, lo}, 64'hFFFFFFFA);
    check("mthi_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; md_op = 3'd5; rs_val = 32'hCAFEF00D; cancel = 1'b1;
    step();
    check("mtlo_cancel", {32'd0, lo}, 64'hFFFFFFFA);
    md_op = 3'd0;
    step();
    check("mult_cancel_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; cancel = 1'b0;

    // Back-to-back: DIV issued on the cycle after a MULT commit.
    issue(3'd0, 32'd6, 32'd7);
    wait_idle(n);
    check("b2b_mult_lo", {32'd0, lo}, 64'd42);
    issue(3'd2, 32'd100, 32'hFFFFFFF9);
    check("b2b_div_busy", {63'd0, busy}, 64'd1);
    wait_idle(n);
    check("b2b_div_lat", 64'(n), 64'd10);
    check("b2b_div_hi", {32'd0, hi}, 64'd2);
    check("b2b_div_lo", {32'd0, lo}, 64'hFFFFFFF2);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      start    = ($urandom_range(0, 2) != 0);
      md_op    = 3'($urandom_range(0, 7));
      cancel   = ($urandom_range(0, 3) == 0);
      md_use_D = $urandom_range(0, 1);
      rs_val   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rt_val = 32'd0;
        1:       rt_val = 32'hFFFFFFFF;
        2:       rt_val = 32'($urandom_range(1, 20));
        default: rt_val = $urandom;
      endcase
      #1;
      check("rand_stall", {63'd0, stall_md}, {63'd0, model_stall()});
      step();
      check("rand_state", {busy, hi, lo}, {m_left > 0, m_hi, m_lo});
    end
    start = 1'b0; cancel = 1'b0; md_use_D = 1'b0;
    wait_idle(n);

    // Reset mid-run without a clock edge.
    issue(3'd2, 32'd1000, 32'd7);
    step();
    step();
    reset = 1'b0;
    #1;
    model_reset();
    check("async_rst", {busy, hi, lo}, 65'd0);
    step();
    check("rst_held", {busy, hi, lo}, 65'd0);
    reset = 1'b1;
    issue(3'd0, 32'd3, 32'd5);
    step();
    reset = 1'b0;
    step();
    check("rst_edge", {busy, hi, lo}, 65'd0);
    reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
